rf_mp: RTL and testbench
========================

Name: rf_mp

Overview:
- Parametrised multi-read-port register file with two write ports and an integrated busy scoreboard.
- Successor to the single-write, two-read CPU register file.
- Adds configurable width, depth and read-port count, plus a hardwired zero register.
- Per-register busy bits support the pipeline's hazard-detection logic: set at issue, cleared at writeback.

Parameters:
- DATA_W, 32, register data width in bits
- ADDR_W, 5, register address width; depth = 2**ADDR_W
- NREAD, 2, number of independent read ports (1..4)
- ZERO_REG, 1, when 1, register 0 reads 0, ignores writes and is never busy

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- rd_addr  in  NREAD*ADDR_W  read addresses; port k occupies bits [k*ADDR_W +: ADDR_W]
- rd_data  out  NREAD*DATA_W  read data; port k occupies bits [k*DATA_W +: DATA_W]
- rd_busy  out  NREAD  busy flag of the addressed register, per read port
- wr0_en  in  1  write port 0 enable (primary writeback, ALU path)
- wr0_addr  in  ADDR_W  write port 0 address
- wr0_data  in  DATA_W  write port 0 data
- wr1_en  in  1  write port 1 enable (secondary writeback, load path)
- wr1_addr  in  ADDR_W  write port 1 address
- wr1_data  in  DATA_W  write port 1 data
- iss_en  in  1  issue strobe; marks iss_addr busy
- iss_addr  in  ADDR_W  destination register of the issuing instruction
- busy_vec  out  2**ADDR_W  registered busy bits, for debug and the stall unit

Behaviour:
- Reset: when rst=1 at posedge clk, all entries become 0 and all busy bits become 0. rst overrides every write and issue in that cycle. Outputs are therefore rd_data=0, rd_busy=0 and busy_vec=0 from the cycle after the reset edge.
- Reads are combinational from the array with zero latency. Addresses must be stable before the clock edge.
- Writes take effect at posedge clk. The new value is visible on rd_data in the following cycle (see Optional Feature for same-cycle visibility).
- Write collision (wr0_en & wr1_en & wr0_addr==wr1_addr): port 0 data is stored and port 1 is dropped.
- ZERO_REG=1:
  - writes to address 0 are ignored;
  - rd_data for address 0 is 0;
  - iss_en to address 0 does not set busy;
  - busy_vec[0] is always 0.
- Scoreboard (per register r, evaluated at posedge, rst=0):
  - set busy[r] when iss_en & iss_addr==r;
  - otherwise clear busy[r] when (wr0_en & wr0_addr==r) | (wr1_en & wr1_addr==r);
  - otherwise hold.
- Issue and writeback to the same register in the same cycle: issue wins and busy stays 1, because a newer producer is in flight. The data write still happens.
- A writeback to a register that is not busy is legal: data is written and busy stays 0.
- rd_busy[k] = busy[rd_addr[k]] (registered value), except as modified by RF_BYPASS_EN.
- No internal FSM beyond the array and the scoreboard. Every cycle is independent apart from the stored state.

Optional Feature:
- Macro: RF_BYPASS_EN.
- Defined: write-through forwarding.
  - If a read address matches an active same-cycle write, rd_data returns that write's data, with port 0 taking priority over port 1.
  - rd_busy for that read port is forced to 0 in the same cycle, unless iss_en targets the same address in that cycle.
  - Address 0 is never forwarded when ZERO_REG=1.
- Not defined: reads return only stored array contents, and rd_busy reflects the registered bit only. A value written at edge N is readable after edge N.

Decomposition:
- Package rf_pkg:
  - default constants RF_DATA_W=32, RF_ADDR_W=5;
  - typedefs rf_addr_t and rf_data_t;
  - constant RF_ZERO_ADDR=0.
- Sub-module rf_scoreboard: busy-bit array with the issue/writeback set/clear priority and the ZERO_REG masking. It is instantiated once inside rf_mp.
- The data array and read muxes stay in rf_mp.

Test Plan:
- Assert rst for 1 cycle after writing 0xDEADBEEF to r5 and issuing r5 -> next cycle rd_data(r5)=0 and busy_vec=0.
- wr0 r3=0x11111111 and wr1 r3=0x22222222 in the same cycle -> r3 reads 0x11111111 the next cycle.
- ZERO_REG=1: wr0 r0=0xFFFFFFFF plus iss_en r0 -> r0 reads 0 and busy_vec[0]=0.
- iss r7 at cycle 1, then wr1 r7=0xA5A5A5A5 together with iss r7 at cycle 4 -> busy[7] stays 1 and r7=0xA5A5A5A5. wr0 r7 at cycle 6 -> busy[7]=0 from cycle 7.
- RF_BYPASS_EN: r9 busy, wr0 r9=0x1234 while port 1 reads r9 in the same cycle -> rd_data=0x1234 and rd_busy=0 that cycle. Without the macro -> old value and rd_busy=1.
- NREAD=4, DATA_W=64: write distinct 64-bit patterns to r1..r4 and read all four ports simultaneously -> each port returns its own pattern with no cross-port aliasing.

Source files
------------

// File: rtl/rf_pkg.sv
// ============================================================================
// Module : rf_pkg
// Brief  : Shared constants and types for the multi-port register file.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package rf_pkg;

  localparam int RF_DATA_W = 32;
  localparam int RF_ADDR_W = 5;

  typedef logic [RF_ADDR_W-1:0] rf_addr_t;
  typedef logic [RF_DATA_W-1:0] rf_data_t;

  localparam rf_addr_t RF_ZERO_ADDR = '0;

endpackage

`default_nettype wire

// File: rtl/rf_scoreboard.sv
// ============================================================================
// Module : rf_scoreboard
// Brief  : Per-register busy bits; issue sets, writeback clears, issue wins.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int ZERO_REG = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr0_en,
  input  logic [ADDR_W-1:0]    wr0_addr,
  input  logic                 wr1_en,
  input  logic [ADDR_W-1:0]    wr1_addr,
  input  logic                 iss_en,
  input  logic [ADDR_W-1:0]    iss_addr,
  output logic [2**ADDR_W-1:0] busy_vec
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DEPTH-1:0] r_busy;

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (rst) begin
        r_busy[i] <= 1'b0;
      end else if ((ZERO_REG != 0) && (ADDR_W'(i) == ADDR_W'(RF_ZERO_ADDR))) begin
        r_busy[i] <= 1'b0;
      end else if (iss_en && (iss_addr == ADDR_W'(i))) begin
        // a newer producer is in flight, so a same-cycle writeback must not clear
        r_busy[i] <= 1'b1;
      end else if ((wr0_en && (wr0_addr == ADDR_W'(i))) ||
                   (wr1_en && (wr1_addr == ADDR_W'(i)))) begin
        r_busy[i] <= 1'b0;
      end
    end
  end

  assign busy_vec = r_busy;

endmodule

`default_nettype wire

// File: rtl/rf_mp.sv
// ============================================================================
// Module : rf_mp
// Brief  : NREAD-read / 2-write register file with busy scoreboard.
//          Optional write-through forwarding under macro RF_BYPASS_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rf_mp
  import rf_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int NREAD    = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREAD*ADDR_W-1:0] rd_addr,
  output logic [NREAD*DATA_W-1:0] rd_data,
  output logic [NREAD-1:0]        rd_busy,
  input  logic                    wr0_en,
  input  logic [ADDR_W-1:0]       wr0_addr,
  input  logic [DATA_W-1:0]       wr0_data,
  input  logic                    wr1_en,
  input  logic [ADDR_W-1:0]       wr1_addr,
  input  logic [DATA_W-1:0]       wr1_data,
  input  logic                    iss_en,
  input  logic [ADDR_W-1:0]       iss_addr,
  output logic [2**ADDR_W-1:0]    busy_vec
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0]  w_busy;
  logic              w_wr0_ok;
  logic              w_wr1_ok;

  assign w_wr0_ok = wr0_en && !((ZERO_REG != 0) && (wr0_addr == ADDR_W'(RF_ZERO_ADDR)));
  assign w_wr1_ok = wr1_en && !((ZERO_REG != 0) && (wr1_addr == ADDR_W'(RF_ZERO_ADDR)));

  // port 0 is checked first, so on an address collision port 1 is dropped
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (rst) begin
        r_mem[i] <= '0;
      end else if (w_wr0_ok && (wr0_addr == ADDR_W'(i))) begin
        r_mem[i] <= wr0_data;
      end else if (w_wr1_ok && (wr1_addr == ADDR_W'(i))) begin
        r_mem[i] <= wr1_data;
      end
    end
  end

  rf_scoreboard #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .wr0_en   (wr0_en),
    .wr0_addr (wr0_addr),
    .wr1_en   (wr1_en),
    .wr1_addr (wr1_addr),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .busy_vec (w_busy)
  );

  assign busy_vec = w_busy;

  for (genvar k = 0; k < NREAD; k++) begin : g_rd
    logic [ADDR_W-1:0] w_addr;
    logic              w_zero;
    logic [DATA_W-1:0] w_data;
    logic              w_bsy;

    assign w_addr = rd_addr[k*ADDR_W +: ADDR_W];
    assign w_zero = (ZERO_REG != 0) && (w_addr == ADDR_W'(RF_ZERO_ADDR));

`ifdef RF_BYPASS_EN
    // forwarded reads report not-busy unless the same address is re-issued now
    always_comb begin
      w_data = w_zero ? '0 : r_mem[w_addr];
      w_bsy  = w_busy[w_addr];
      if (!w_zero && wr0_en && (wr0_addr == w_addr)) begin
        w_data = wr0_data;
        w_bsy  = iss_en && (iss_addr == w_addr);
      end else if (!w_zero && wr1_en && (wr1_addr == w_addr)) begin
        w_data = wr1_data;
        w_bsy  = iss_en && (iss_addr == w_addr);
      end
    end
`else
    assign w_data = w_zero ? '0 : r_mem[w_addr];
    assign w_bsy  = w_busy[w_addr];
`endif

    assign rd_data[k*DATA_W +: DATA_W] = w_data;
    assign rd_busy[k]                  = w_bsy;
  end

endmodule

`default_nettype wire

// File: tb/tb_rf_mp.sv
// ============================================================================
// Module : tb_rf_mp
// Brief  : Self-checking bench for rf_mp: directed steps plus random traffic
//          against an array-based reference model; a second 4x64 instance.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_rf_mp;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic        wr0_en, wr1_en, iss_en;
  logic [4:0]  wr0_addr, wr1_addr, iss_addr;
  logic [31:0] wr0_data, wr1_data;
  logic [31:0] busy_vec;

  logic [19:0]  q_rd_addr;
  logic [255:0] q_rd_data;
  logic [3:0]   q_rd_busy;
  logic         q_wr0_en, q_wr1_en;
  logic [4:0]   q_wr0_addr, q_wr1_addr;
  logic [63:0]  q_wr0_data, q_wr1_data;
  logic [31:0]  q_busy_vec;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] m_mem [32];
  logic [31:0] m_busy;

  always #5 clk = ~clk;

  rf_mp dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
    .iss_en(iss_en), .iss_addr(iss_addr), .busy_vec(busy_vec)
  );

  rf_mp #(.DATA_W(64), .ADDR_W(5), .NREAD(4), .ZERO_REG(1)) dut4 (
    .clk(clk), .rst(rst), .rd_addr(q_rd_addr), .rd_data(q_rd_data), .rd_busy(q_rd_busy),
    .wr0_en(q_wr0_en), .wr0_addr(q_wr0_addr), .wr0_data(q_wr0_data),
    .wr1_en(q_wr1_en), .wr1_addr(q_wr1_addr), .wr1_data(q_wr1_data),
    .iss_en(1'b0), .iss_addr(5'd0), .busy_vec(q_busy_vec)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_data(input logic [4:0] a);
    logic [31:0] v;
    v = (a == 5'd0) ? 32'd0 : m_mem[a];
`ifdef RF_BYPASS_EN
    if (a != 5'd0 && wr0_en && wr0_addr == a)      v = wr0_data;
    else if (a != 5'd0 && wr1_en && wr1_addr == a) v = wr1_data;
`endif
    return v;
  endfunction

  function automatic logic exp_busy(input logic [4:0] a);
    logic b;
    b = m_busy[a];
`ifdef RF_BYPASS_EN
    if (a != 5'd0 && ((wr0_en && wr0_addr == a) || (wr1_en && wr1_addr == a)))
      b = iss_en && (iss_addr == a);
`endif
    return b;
  endfunction

  task automatic idle();
    wr0_en = 0; wr1_en = 0; iss_en = 0;
    wr0_addr = '0; wr1_addr = '0; iss_addr = '0;
    wr0_data = '0; wr1_data = '0;
  endtask

  // compare both combinational read ports against the model before the edge
  task automatic settle();
    #2;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rd_data%0d", k), {32'd0, rd_data[k*32 +: 32]},
          {32'd0, exp_data(rd_addr[k*5 +: 5])});
      chk($sformatf("rd_busy%0d", k), {63'd0, rd_busy[k]},
          {63'd0, exp_busy(rd_addr[k*5 +: 5])});
    end
  endtask

  // advance one edge and apply the architectural rules to the model
  task automatic edge_step();
    logic [31:0] nb;
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) m_mem[i] = '0;
      m_busy = '0;
    end else begin
      nb = m_busy;
      if (wr0_en) nb[wr0_addr] = 1'b0;
      if (wr1_en) nb[wr1_addr] = 1'b0;
      if (iss_en) nb[iss_addr] = 1'b1;
      nb[0] = 1'b0;
      if (wr1_en && !(wr0_en && wr0_addr == wr1_addr)) m_mem[wr1_addr] = wr1_data;
      if (wr0_en) m_mem[wr0_addr] = wr0_data;
      m_mem[0] = '0;
      m_busy = nb;
    end
    #1;
    chk("busy_vec", {32'd0, busy_vec}, {32'd0, m_busy});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1; idle(); rd_addr = '0;
    q_wr0_en = 0; q_wr1_en = 0; q_wr0_addr = '0; q_wr1_addr = '0;
    q_wr0_data = '0; q_wr1_data = '0; q_rd_addr = '0;
    m_busy = '0;
    @(negedge clk);
    edge_step();
    rst = 0;
    settle();
    chk("reset_rd0", rd_data, 64'd0);

    // reset clears a written and issued register
    wr0_en = 1; wr0_addr = 5; wr0_data = 32'hDEADBEEF; iss_en = 1; iss_addr = 5;
    rd_addr = {5'd5, 5'd5};
    settle(); edge_step();
    idle(); settle();
    chk("pre_rst_r5", {32'd0, rd_data[31:0]}, 64'hDEADBEEF);
    chk("pre_rst_busy5", {63'd0, busy_vec[5]}, 64'd1);
    rst = 1;
    settle(); edge_step();
    rst = 0;
    settle();
    chk("rst_r5", {32'd0, rd_data[31:0]}, 64'd0);
    chk("rst_busyvec", {32'd0, busy_vec}, 64'd0);

    // write collision: port 0 wins
    wr0_en = 1; wr0_addr = 3; wr0_data = 32'h11111111;
    wr1_en = 1; wr1_addr = 3; wr1_data = 32'h22222222;
    rd_addr = {5'd3, 5'd3};
    settle(); edge_step();
    idle(); settle();
    chk("collision_r3", {32'd0, rd_data[31:0]}, 64'h11111111);

    // zero register ignores writes and issue
    wr0_en = 1; wr0_addr = 0; wr0_data = 32'hFFFFFFFF; iss_en = 1; iss_addr = 0;
    rd_addr = {5'd0, 5'd0};
    settle(); edge_step();
    idle(); settle();
    chk("zero_r0", {32'd0, rd_data[31:0]}, 64'd0);
    chk("zero_busy0", {63'd0, busy_vec[0]}, 64'd0);

    // issue beats same-cycle writeback; later writeback clears
    rd_addr = {5'd7, 5'd7};
    iss_en = 1; iss_addr = 7; settle(); edge_step();
    idle(); settle(); edge_step();
    settle(); edge_step();
    wr1_en = 1; wr1_addr = 7; wr1_data = 32'hA5A5A5A5; iss_en = 1; iss_addr = 7;
    settle(); edge_step();
    idle(); settle();
    chk("iss_wins_busy7", {63'd0, busy_vec[7]}, 64'd1);
    chk("iss_wins_r7", {32'd0, rd_data[31:0]}, 64'hA5A5A5A5);
    edge_step();
    wr0_en = 1; wr0_addr = 7; wr0_data = 32'h77777777;
    settle(); edge_step();
    idle(); settle();
    chk("wb_clear_busy7", {63'd0, busy_vec[7]}, 64'd0);

    // same-cycle read of a register being written
    wr0_en = 1; wr0_addr = 9; wr0_data = 32'h00009999; iss_en = 1; iss_addr = 9;
    settle(); edge_step();
    idle();
    wr0_en = 1; wr0_addr = 9; wr0_data = 32'h00001234;
    rd_addr = {5'd9, 5'd2};
    #2;
`ifdef RF_BYPASS_EN
    chk("bypass_rd9", {32'd0, rd_data[63:32]}, 64'h1234);
    chk("bypass_busy9", {63'd0, rd_busy[1]}, 64'd0);
`else
    chk("nobypass_rd9", {32'd0, rd_data[63:32]}, 64'h9999);
    chk("nobypass_busy9", {63'd0, rd_busy[1]}, 64'd1);
`endif
    settle(); edge_step();
    idle(); settle();
    chk("after_wr_r9", {32'd0, rd_data[63:32]}, 64'h1234);

    // random traffic on a narrow address window to provoke collisions
    for (int n = 0; n < 300; n++) begin
      wr0_en   = ($urandom_range(0, 2) == 0);
      wr1_en   = ($urandom_range(0, 2) == 0);
      iss_en   = ($urandom_range(0, 2) == 0);
      wr0_addr = 5'($urandom_range(0, 11));
      wr1_addr = 5'($urandom_range(0, 11));
      iss_addr = 5'($urandom_range(0, 11));
      wr0_data = $urandom;
      wr1_data = $urandom;
      rd_addr  = {5'($urandom_range(0, 11)), 5'($urandom_range(0, 11))};
      settle(); edge_step();
    end
    idle();

    // wide 4-port instance: distinct patterns, no cross-port aliasing
    q_wr0_en = 1; q_wr0_addr = 1; q_wr0_data = 64'h0101_0101_A1A1_A1A1;
    q_wr1_en = 1; q_wr1_addr = 2; q_wr1_data = 64'h0202_0202_B2B2_B2B2;
    @(posedge clk); #1;
    q_wr0_addr = 3; q_wr0_data = 64'h0303_0303_C3C3_C3C3;
    q_wr1_addr = 4; q_wr1_data = 64'h0404_0404_D4D4_D4D4;
    @(posedge clk); #1;
    q_wr0_en = 0; q_wr1_en = 0;
    q_rd_addr = {5'd4, 5'd3, 5'd2, 5'd1};
    #2;
    chk("w64_p0", q_rd_data[0*64 +: 64], 64'h0101_0101_A1A1_A1A1);
    chk("w64_p1", q_rd_data[1*64 +: 64], 64'h0202_0202_B2B2_B2B2);
    chk("w64_p2", q_rd_data[2*64 +: 64], 64'h0303_0303_C3C3_C3C3);
    chk("w64_p3", q_rd_data[3*64 +: 64], 64'h0404_0404_D4D4_D4D4);
    q_rd_addr = {5'd1, 5'd2, 5'd3, 5'd4};
    #2;
    chk("w64_rev_p0", q_rd_data[0*64 +: 64], 64'h0404_0404_D4D4_D4D4);
    chk("w64_rev_p3", q_rd_data[3*64 +: 64], 64'h0101_0101_A1A1_A1A1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
